// File: rtl/haddx_serial_sched.sv
// Bit-serial adder scheduler: two requesters share one half-adder-pair slice, arbitrated
// round-robin; the sum is produced LSB-first over WIDTH cycles with a registered carry.
module haddx_serial_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             done_o,
  output logic             done_id_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_id_q, done_id_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             pick1;

  // Shared slice: two half adders, OR2 merges their carries.
  logic ha0_s, ha0_c, ha1_s, ha1_c, slice_c;
  assign ha0_s   = a_q[0] ^ b_q[0];
  assign ha0_c   = a_q[0] & b_q[0];
  assign ha1_s   = ha0_s ^ carry_q;
  assign ha1_c   = ha0_s & carry_q;
  assign slice_c = ha0_c | ha1_c;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    done_id_d = done_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    pick1     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          // On a tie the requester that did not win last time goes first.
          pick1   = req1_i && (!req0_i || !last_q);
          last_d  = pick1;
          id_d    = pick1;
          a_d     = pick1 ? a1_i : a0_i;
          b_d     = pick1 ? b1_i : b0_i;
          carry_d = 1'b0;
          cnt_d   = '0;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = {ha1_s, acc_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d     = {ha1_s, acc_q[WIDTH-1:1]};
          cout_d    = slice_c;
          done_id_d = id_q;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      done_id_q <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      done_id_q <= done_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
    end
  end

  assign gnt0_o    = gnt0_q;
  assign gnt1_o    = gnt1_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign done_id_o = done_id_q;

endmodule

// File: tb/tb_haddx_serial_sched.sv
// Bench for haddx_serial_sched: scoreboard of expected results checked at each DONE,
// plus per-scenario grant/latency checks; a second instance covers WIDTH=2.
module tb_haddx_serial_sched;

  typedef struct packed {
    logic       id;
    logic       cout;
    logic [7:0] sum;
  } exp_t;

  logic       clk, rst_n;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, busy, cout, done, done_id;
  logic [7:0] sum;

  logic       r2;
  logic [1:0] a2, b2;
  logic       g2_0, g2_1, busy2, cout2, done2, did2;
  logic [1:0] sum2;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   last_m = 1'b1;
  logic prev_done = 1'b0;

  haddx_serial_sched #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .req0_i(req0), .req1_i(req1),
    .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy), .sum_o(sum), .cout_o(cout),
    .done_o(done), .done_id_o(done_id)
  );

  haddx_serial_sched #(.WIDTH(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req0_i(r2), .req1_i(1'b0),
    .a0_i(a2), .b0_i(b2), .a1_i(2'b00), .b1_i(2'b00),
    .gnt0_o(g2_0), .gnt1_o(g2_1), .busy_o(busy2), .sum_o(sum2), .cout_o(cout2),
    .done_o(done2), .done_id_o(did2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic id, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return '{id: id, cout: s[8], sum: s[7:0]};
  endfunction

  // Scoreboard: every DONE pops one expected result; DONE must never last two cycles.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_pulse: DONE high %0d consecutive cycles, required 1", 2);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: DONE with no expected result pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({done_id, cout, sum} !== {e.id, e.cout, e.sum})
          begin
            errors++;
            $display("FAIL result: id=%0d cout=%0d sum=%h, required id=%0d cout=%0d sum=%h",
                     done_id, cout, sum, e.id, e.cout, e.sum);
          end
      end
    end
    prev_done = rst_n && done;
  end

  task automatic wait_grant(output int gid, output int cyc);
    gid = -1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        gid = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, busy, cout, done, done_id} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: gnt0/gnt1/busy/cout/done/done_id=%b, required 000000",
               {gnt0, gnt1, busy, cout, done, done_id});
    end
    checks++;
    if (sum !== 8'h00) begin
      errors++;
      $display("FAIL reset_sum: sum=%h, required 00", sum);
    end
    checks++;
    if ({g2_0, g2_1, busy2, done2, cout2, did2, sum2} !== 8'b0) begin
      errors++;
      $display("FAIL reset_w2: outputs=%b, required 00000000",
               {g2_0, g2_1, busy2, done2, cout2, did2, sum2});
    end
    rst_n  = 1'b1;
    last_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tie();
    int gid, cyc;
    a0 = 8'h3C; b0 = 8'h0F; a1 = 8'hFF; b1 = 8'h01;
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back(mk(1'b0, 8'h3C, 8'h0F));
    sb.push_back(mk(1'b1, 8'hFF, 8'h01));
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 0) begin
      errors++;
      $display("FAIL tie_first: granted %0d, required 0", gid);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL tie_busy: busy=%b in grant cycle, required 1", busy);
    end
    req0 = 1'b0;
    last_m = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL gnt_pulse: gnt0=%b one cycle after grant, required 0", gnt0);
    end
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 1 || cyc + 1 != 10) begin
      errors++;
      $display("FAIL tie_second: granted %0d after %0d cycles, required 1 after 10",
               gid, cyc + 1);
    end
    req1 = 1'b0;
    last_m = 1'b1;
    wait_drain();
  endtask

  task automatic test_fairness();
    int gid, cyc, prev;
    logic w;
    prev = -1;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = !last_m;
      sb.push_back(w ? mk(1'b1, a1, b1) : mk(1'b0, a0, b0));
      wait_grant(gid, cyc);
      checks++;
      if (gid !== int'(w) || gid == prev) begin
        errors++;
        $display("FAIL fair_%0d: granted %0d, required %0d (previous %0d)", i, gid, w, prev);
      end
      prev = gid;
      last_m = w;
      if (w) begin
        a1 = 8'($urandom); b1 = 8'($urandom);
      end else begin
        a0 = 8'($urandom); b0 = 8'($urandom);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_drain();
  endtask

  task automatic test_single();
    int gid, cyc, n;
    a0 = 8'hA5; b0 = 8'h5B; req0 = 1'b1;
    sb.push_back(mk(1'b0, 8'hA5, 8'h5B));
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 0) begin
      errors++;
      $display("FAIL single_gnt: granted %0d, required 0", gid);
    end
    req0 = 1'b0; a0 = 8'h00; b0 = 8'h00;
    last_m = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL single_latency: DONE %0d cycles after GNT, required 8", n);
    end
    wait_drain();
  endtask

  task automatic test_late_req();
    int gid, cyc, n;
    exp_t prev_e;
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    prev_e = mk(1'b0, a0, b0);
    sb.push_back(prev_e);
    wait_grant(gid, cyc);
    req0 = 1'b0;
    last_m = 1'b0;
    repeat (3) @(negedge clk);
    a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1;
    sb.push_back(mk(1'b1, a1, b1));
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 1 || cyc + 3 != 10) begin
      errors++;
      $display("FAIL late_gnt: granted %0d %0d cycles after first, required 1 after 10",
               gid, cyc + 3);
    end
    req1 = 1'b0;
    last_m = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done || n > 40) break;
      checks++;
      if ({done_id, cout, sum} !== {prev_e.id, prev_e.cout, prev_e.sum}) begin
        errors++;
        $display("FAIL late_hold: id=%0d cout=%0d sum=%h, required id=%0d cout=%0d sum=%h",
                 done_id, cout, sum, prev_e.id, prev_e.cout, prev_e.sum);
      end
    end
    wait_drain();
  endtask

  task automatic test_reset_mid_run();
    int gid, cyc, seen;
    a0 = 8'h77; b0 = 8'h99; req0 = 1'b1;
    wait_grant(gid, cyc);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, busy, cout, done, done_id, sum} !== 14'b0) begin
      errors++;
      $display("FAIL midrst_async: outputs=%b, required all zero",
               {gnt0, gnt1, busy, cout, done, done_id, sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1'b1;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_quiet: busy/done seen %0d cycles after release, required 0", seen);
    end
    a0 = 8'h12; b0 = 8'h34; a1 = 8'h56; b1 = 8'h78;
    req0 = 1'b1; req1 = 1'b1;
    sb.push_back(mk(1'b0, 8'h12, 8'h34));
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 0) begin
      errors++;
      $display("FAIL midrst_tie: granted %0d, required 0", gid);
    end
    req0 = 1'b0; req1 = 1'b0;
    last_m = 1'b0;
    wait_drain();
  endtask

  task automatic test_width2();
    int n, g;
    a2 = 2'b11; b2 = 2'b11; r2 = 1'b1;
    g = 0;
    while (!g2_0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    r2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
    checks++;
    if (g2_0 !== 1'b1) begin
      errors++;
      $display("FAIL w2_gnt: gnt0=%b, required 1", g2_0);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done2 && n < 20);
    checks++;
    if (n != 2 || {did2, cout2, sum2} !== 4'b0110) begin
      errors++;
      $display("FAIL w2_result: latency=%0d id=%0d cout=%0d sum=%b, required 2 0 1 10",
               n, did2, cout2, sum2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; r2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    test_reset();
    test_tie();
    test_fairness();
    test_single();
    test_late_req();
    test_reset_mid_run();
    test_width2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
